// File: rtl/tiny_gpu_top.sv
// Tiny matrix-vector accelerator: fetches X[4] and W[4][4] over a
// single-outstanding read port, streams Y = W*X one row at a time.
module tiny_gpu_top #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] cfg_data,
  output logic                  m_req_vld,
  input  logic                  m_req_rdy,
  output logic [ADDR_WIDTH-1:0] m_req_addr,
  input  logic                  m_rsp_vld,
  output logic                  m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  result_vld,
  input  logic                  result_rdy,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_X_REQ,
    S_X_WAIT,
    S_W_REQ,
    S_W_WAIT,
    S_OUT
  } state_t;

  localparam logic [1:0] OP_SET_W = 2'b00;
  localparam logic [1:0] OP_SET_X = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_w_base;
  logic [ADDR_WIDTH-1:0] r_x_base;
  logic [1:0]            r_col;
  logic [1:0]            r_row;
  logic [DATA_WIDTH-1:0] r_x [4];
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_res;

  logic [ADDR_WIDTH-1:0] w_x_addr;
  logic [ADDR_WIDTH-1:0] w_w_addr;
  logic [ACC_WIDTH-1:0]  w_prod;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_cmd;

  assign w_cmd    = start && (r_state == S_IDLE);
  assign w_x_addr = r_x_base + ADDR_WIDTH'(r_col);
  assign w_w_addr = r_w_base + ADDR_WIDTH'({r_row, r_col});
  assign w_prod   = ACC_WIDTH'(m_rsp_data) * ACC_WIDTH'(r_x[r_col]);
  assign w_sum    = r_acc + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    m_req_vld  = 1'b0;
    m_req_addr = '0;
    m_rsp_rdy  = 1'b0;
    result_vld = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_cmd && op_code == OP_RUN) w_next = S_X_REQ;
      end
      S_X_REQ: begin
        m_req_vld  = 1'b1;
        m_req_addr = w_x_addr;
        if (m_req_rdy) w_next = S_X_WAIT;
      end
      S_X_WAIT: begin
        m_rsp_rdy = 1'b1;
        if (m_rsp_vld)
          w_next = (r_col == 2'd3) ? S_W_REQ : S_X_REQ;
      end
      S_W_REQ: begin
        m_req_vld  = 1'b1;
        m_req_addr = w_w_addr;
        if (m_req_rdy) w_next = S_W_WAIT;
      end
      S_W_WAIT: begin
        m_rsp_rdy = 1'b1;
        if (m_rsp_vld)
          w_next = (r_col == 2'd3) ? S_OUT : S_W_REQ;
      end
      S_OUT: begin
        result_vld = 1'b1;
        if (result_rdy)
          w_next = (r_row == 2'd3) ? S_IDLE : S_W_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Column counter wraps 3->0 naturally, so each row restarts at column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_base <= '0;
      r_x_base <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd) begin
            unique case (op_code)
              OP_SET_W: r_w_base <= cfg_data;
              OP_SET_X: r_x_base <= cfg_data;
              OP_RUN: begin
                r_col <= '0;
                r_row <= '0;
                r_acc <= '0;
              end
              default: ;
            endcase
          end
        end
        S_X_WAIT: begin
          if (m_rsp_vld) begin
            r_x[r_col] <= m_rsp_data;
            r_col      <= r_col + 2'd1;
          end
        end
        S_W_WAIT: begin
          if (m_rsp_vld) begin
            r_col <= r_col + 2'd1;
            if (r_col == 2'd3) begin
              r_res <= w_sum;
              r_acc <= '0;
            end else begin
              r_acc <= w_sum;
            end
          end
        end
        S_OUT: begin
          if (result_rdy) r_row <= r_row + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign result_data = r_res;

endmodule

// File: tb/tb_tiny_gpu_top.sv
// Bench for tiny_gpu_top: memory responder, result scoreboard,
// table of RUN cases plus busy-command and mid-run reset sequences.
module tb_tiny_gpu_top;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ACCW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op_code = 2'b00;
  logic [AW-1:0]   cfg_data = '0;
  logic            m_req_vld;
  logic            m_req_rdy = 1'b0;
  logic [AW-1:0]   m_req_addr;
  logic            m_rsp_vld = 1'b0;
  logic            m_rsp_rdy;
  logic [DW-1:0]   m_rsp_data = '0;
  logic            result_vld;
  logic            result_rdy = 1'b0;
  logic [ACCW-1:0] result_data;
  logic            busy;

  tiny_gpu_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .cfg_data(cfg_data), .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy),
    .m_req_addr(m_req_addr), .m_rsp_vld(m_rsp_vld),
    .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .result_vld(result_vld), .result_rdy(result_rdy),
    .result_data(result_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]   mem [256];
  logic [AW-1:0]   exp_addr_q [$];
  logic [ACCW-1:0] exp_res_q [$];

  bit req_stall = 0;
  bit spurious = 0;
  int rsp_delay = 0;
  int bp_row = -1;
  int res_seen = 0;
  int hold = 0;
  int run_cyc = 0;
  int rise_cyc [$];
  int fall_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory responder: single outstanding read, optional stalls.
  bit            pend = 0;
  logic [AW-1:0] pend_addr = '0;
  int            dly = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend = 0;
      m_req_rdy = 1'b0;
      m_rsp_vld = 1'b0;
    end else begin
      chk("req_rsp_overlap", {63'd0, m_req_vld & m_rsp_rdy}, 0);
      if (pend) begin
        m_req_rdy = 1'b0;
        chk("req_while_pending", {63'd0, m_req_vld}, 0);
        if (dly > 0) begin
          dly--;
          m_rsp_vld = 1'b0;
        end else begin
          m_rsp_vld = 1'b1;
          m_rsp_data = mem[pend_addr];
          if (m_rsp_rdy) pend = 0;
        end
      end else begin
        m_req_rdy = req_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_rsp_vld = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        m_rsp_data = 8'hEE;
        if (m_req_vld && m_req_rdy) begin
          chk("addr_expected", {63'd0, exp_addr_q.size() != 0}, 1);
          if (exp_addr_q.size() != 0)
            chk("req_addr", m_req_addr, exp_addr_q.pop_front());
          pend = 1;
          pend_addr = m_req_addr;
          dly = rsp_delay;
        end
      end
    end
  end

  // Result consumer and scoreboard.
  logic            prev_vld = 0;
  logic            prev_hs = 0;
  logic            prev_busy = 0;
  logic [ACCW-1:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      result_rdy = 1'b0;
      prev_vld = 0;
      prev_hs = 0;
      prev_busy = 0;
    end else begin
      if (prev_hs)
        chk("vld_drop_after_hs", {63'd0, result_vld}, 0);
      else if (prev_vld && result_vld)
        chk("result_stable", result_data, prev_data);
      if (result_vld)
        chk("no_req_in_out", {63'd0, m_req_vld}, 0);
      if (result_vld && !prev_vld) rise_cyc.push_back(cyc);
      if (!busy && prev_busy) fall_cyc = cyc;
      if (result_vld && res_seen == bp_row && hold < 5) begin
        result_rdy = 1'b0;
        hold++;
      end else begin
        result_rdy = 1'b1;
      end
      prev_hs = result_vld && result_rdy;
      if (prev_hs) begin
        chk("result_expected", {63'd0, exp_res_q.size() != 0}, 1);
        if (exp_res_q.size() != 0)
          chk("result", result_data, exp_res_q.pop_front());
        res_seen++;
      end
      prev_vld = result_vld;
      prev_data = result_data;
      prev_busy = busy;
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [AW-1:0] d);
    @(negedge clk);
    start = 1'b1;
    op_code = op;
    cfg_data = d;
    @(negedge clk);
    start = 1'b0;
    op_code = 2'b00;
    cfg_data = '0;
  endtask

  task automatic start_run(input logic [AW-1:0] wb,
                           input logic [AW-1:0] xb,
                           input logic [ACCW-1:0] y [4]);
    rise_cyc.delete();
    fall_cyc = -1;
    res_seen = 0;
    hold = 0;
    for (int c = 0; c < 4; c++) exp_addr_q.push_back(xb + AW'(c));
    for (int a = 0; a < 16; a++) exp_addr_q.push_back(wb + AW'(a));
    for (int r = 0; r < 4; r++) exp_res_q.push_back(y[r]);
    cmd(2'b10, '0);
    run_cyc = cyc;
    chk("busy_after_run", {63'd0, busy}, 1);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 3000 && res_seen < 4; i++) @(negedge clk);
    chk("run_results", res_seen, 4);
    repeat (2) @(negedge clk);
    chk("busy_done", {63'd0, busy}, 0);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("res_q_empty", exp_res_q.size(), 0);
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) mem[i] = (pat == 1) ? 8'hFF : 8'h00;
    if (pat == 0) begin
      for (int i = 0; i < 16; i++) mem[i] = DW'(i + 2);
      mem[16] = 8'd18;
      mem[17] = 8'd19;
      mem[18] = 8'd20;
      mem[19] = 8'd20;
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_m_req_vld"}, {63'd0, m_req_vld}, 0);
    chk({tag, "_m_req_addr"}, m_req_addr, 0);
    chk({tag, "_m_rsp_rdy"}, {63'd0, m_rsp_rdy}, 0);
    chk({tag, "_result_vld"}, {63'd0, result_vld}, 0);
    chk({tag, "_result_data"}, result_data, 0);
    chk({tag, "_busy"}, {63'd0, busy}, 0);
  endtask

  typedef struct {
    logic [AW-1:0]   wb;
    logic [AW-1:0]   xb;
    int              pat;
    bit              stall;
    int              dly;
    int              bp;
    bit              timing;
    logic [ACCW-1:0] y [4];
  } vec_t;

  vec_t tbl [4];
  logic [ACCW-1:0] y_basic [4];
  logic [ACCW-1:0] y_zero_base [4];

  initial begin
    y_basic = '{32'd273, 32'd581, 32'd889, 32'd1197};
    y_zero_base = '{32'd54, 32'd110, 32'd166, 32'd222};
    tbl[0] = '{8'h00, 8'h10, 0, 0, 0, -1, 1, y_basic};
    tbl[1] = '{8'h00, 8'h10, 0, 0, 0, 1, 0, y_basic};
    tbl[2] = '{8'h00, 8'h10, 0, 1, 3, -1, 0, y_basic};
    tbl[3] = '{8'hF8, 8'h40, 1, 1, 1, -1, 0,
               '{32'd260100, 32'd260100, 32'd260100, 32'd260100}};

    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", {63'd0, busy}, 0);
    chk("post_reset_req", {63'd0, m_req_vld}, 0);

    foreach (tbl[k]) begin
      fill(tbl[k].pat);
      req_stall = tbl[k].stall;
      spurious = tbl[k].stall;
      rsp_delay = tbl[k].dly;
      bp_row = tbl[k].bp;
      cmd(2'b00, tbl[k].wb);
      chk("set_w_busy", {63'd0, busy}, 0);
      cmd(2'b01, tbl[k].xb);
      chk("set_x_busy", {63'd0, busy}, 0);
      start_run(tbl[k].wb, tbl[k].xb, tbl[k].y);
      wait_run();
      if (tbl[k].timing) begin
        chk("rise_count", rise_cyc.size(), 4);
        for (int i = 0; i < rise_cyc.size() && i < 4; i++)
          chk("row_latency", rise_cyc[i] - run_cyc, 16 + 9 * i);
        chk("busy_fall", fall_cyc - run_cyc, 44);
      end
    end

    req_stall = 0;
    spurious = 0;
    rsp_delay = 0;
    bp_row = -1;
    fill(0);
    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h10);
    cmd(2'b11, 8'hAA);
    chk("noop_busy", {63'd0, busy}, 0);
    start_run(8'h00, 8'h10, y_basic);
    repeat (6) @(negedge clk);
    cmd(2'b00, 8'h40);
    wait_run();
    start_run(8'h00, 8'h10, y_basic);
    wait_run();

    start_run(8'h00, 8'h10, y_basic);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midrun_reset");
    repeat (3) @(negedge clk);
    exp_addr_q.delete();
    exp_res_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    start_run(8'h00, 8'h00, y_zero_base);
    wait_run();
    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h10);
    start_run(8'h00, 8'h10, y_basic);
    wait_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
